// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, colour mode type and pipeline control word
package vga_pkg;

    // Default 640x480@60 timing (25 MHz pixel clock)
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    typedef enum logic {
        CM_GRAY   = 1'b0,
        CM_RGB332 = 1'b1
    } color_mode_e;

    // Per-pixel control word that travels alongside the RAM read
    typedef struct packed {
        logic        hsync;
        logic        vsync;
        logic        active;
        logic        in_win;
        logic        frame_start;
        color_mode_e mode;
    } pix_ctl_t;

    localparam pix_ctl_t PIX_CTL_IDLE = '{
        hsync:       1'b1,
        vsync:       1'b1,
        active:      1'b0,
        in_win:      1'b0,
        frame_start: 1'b0,
        mode:        CM_GRAY
    };

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // RGB332 to 24-bit by bit replication: returns {r, g, b}
    function automatic logic [23:0] rgb332_expand(input logic [7:0] p);
        return {p[7:5], p[7:5], p[7:6],
                p[4:2], p[4:2], p[4:3],
                p[1:0], p[1:0], p[1:0], p[1:0]};
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel/line counters with sync and active-video decode
// Ports:
//   clk, reset          pixel clock, async active-high reset
//   h_cnt, v_cnt        current pixel / line position (stage 0)
//   hsync, vsync        active-low syncs decoded from the counters (combinational)
//   active              visible-area flag
//   frame_end           high on the last pixel of the last line
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int HW       = 10,
    parameter int VW       = 10
) (
    input  logic          clk,
    input  logic          reset,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          hsync,
    output logic          vsync,
    output logic          active,
    output logic          frame_end
);

    localparam int H_TOT = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
                v_cnt <= '0;
            end else begin
                v_cnt <= v_cnt + VW'(1);
            end
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // Decodes stay combinational; the top registers them into its latency pipe
    always_comb begin
        hsync     = !((h_cnt >= HS_START) && (h_cnt < HS_END));
        vsync     = !((v_cnt >= VS_START) && (v_cnt < VS_END));
        active    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
    end

endmodule

// File: rtl/vga_window_scaler.sv
// rtl/vga_window_scaler.sv - VGA back end with positioned, integer-scaled framebuffer window
// Ports:
//   clk, reset                  pixel clock, async active-high reset
//   win_x, win_y                window top-left corner (shadowed at frame end)
//   scale_sh                    scale = 1 << scale_sh, 3 treated as 2 (shadowed)
//   color_mode                  0 gray replicate, 1 RGB332 expand (shadowed)
//   ram_addr, ram_rdata         framebuffer read port, data RAM_LAT cycles after address
//   hsync, vsync, blank, sync   active-low syncs, blank high = video on, sync tied 0
//   rgb_r, rgb_g, rgb_b         colour, aligned with syncs
//   frame_start                 pulse with the first active pixel of each frame
module vga_window_scaler
    import vga_pkg::*;
#(
    parameter int         H_ACTIVE = VGA_H_ACTIVE,
    parameter int         H_FP     = VGA_H_FP,
    parameter int         H_SYNC   = VGA_H_SYNC,
    parameter int         H_BP     = VGA_H_BP,
    parameter int         V_ACTIVE = VGA_V_ACTIVE,
    parameter int         V_FP     = VGA_V_FP,
    parameter int         V_SYNC   = VGA_V_SYNC,
    parameter int         V_BP     = VGA_V_BP,
    parameter int         IMG_W    = 256,
    parameter int         IMG_H    = 256,
    parameter int         ADDR_W   = 16,
    parameter int         RAM_LAT  = 1,
    parameter logic [7:0] BORDER   = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        win_x,
    input  logic [9:0]        win_y,
    input  logic [1:0]        scale_sh,
    input  logic              color_mode,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [7:0]        ram_rdata,
    output logic              hsync,
    output logic              vsync,
    output logic              blank,
    output logic              sync,
    output logic [7:0]        rgb_r,
    output logic [7:0]        rgb_g,
    output logic [7:0]        rgb_b,
    output logic              frame_start
);

    localparam int H_TOT    = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT    = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW       = $clog2(H_TOT);
    localparam int VW       = $clog2(V_TOT);
    localparam int IMG_W_LG = $clog2(IMG_W);
    // Control stages between the counters and the output register:
    // one for the address register plus one per RAM latency cycle
    localparam int PIPE_D   = RAM_LAT + 1;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          tg_hsync;
    logic          tg_vsync;
    logic          tg_active;
    logic          tg_frame_end;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clk       (clk),
        .reset     (reset),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .hsync     (tg_hsync),
        .vsync     (tg_vsync),
        .active    (tg_active),
        .frame_end (tg_frame_end)
    );

    // Shadow window settings: loaded only on the final pixel of a frame so
    // the whole next frame sees one consistent geometry and colour mode
    logic [9:0]  sh_wx;
    logic [9:0]  sh_wy;
    logic [1:0]  sh_s;
    color_mode_e sh_mode;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_wx   <= '0;
            sh_wy   <= '0;
            sh_s    <= '0;
            sh_mode <= CM_GRAY;
        end else if (tg_frame_end) begin
            sh_wx   <= win_x;
            sh_wy   <= win_y;
            sh_s    <= (scale_sh == 2'd3) ? 2'd2 : scale_sh;
            sh_mode <= color_mode_e'(color_mode);
        end
    end

    // Stage 0: window hit test and source address
    logic [15:0]       h16, v16, wx16, wy16;
    logic [15:0]       dx, dy, span_w, span_h, xs, ys;
    logic              in_win;
    logic [ADDR_W-1:0] addr_next;
    pix_ctl_t          ctl0;

    always_comb begin
        h16    = 16'(h_cnt);
        v16    = 16'(v_cnt);
        wx16   = 16'(sh_wx);
        wy16   = 16'(sh_wy);
        dx     = h16 - wx16;
        dy     = v16 - wy16;
        span_w = 16'(IMG_W) << sh_s;
        span_h = 16'(IMG_H) << sh_s;
        // dx/dy wrap when the position is left of / above the window,
        // so the explicit >= tests are what reject those pixels
        in_win = tg_active
              && (h16 >= wx16) && (dx < span_w)
              && (v16 >= wy16) && (dy < span_h);
        xs     = dx >> sh_s;
        ys     = dy >> sh_s;
        // IMG_W is a power of two and xs < IMG_W, so OR equals the row add
        addr_next = in_win ? ((ADDR_W'(ys) << IMG_W_LG) | ADDR_W'(xs)) : '0;

        ctl0.hsync       = tg_hsync;
        ctl0.vsync       = tg_vsync;
        ctl0.active      = tg_active;
        ctl0.in_win      = in_win;
        ctl0.frame_start = (h_cnt == '0) && (v_cnt == '0);
        ctl0.mode        = sh_mode;
    end

    // Address register plus control delay matching the RAM latency
    pix_ctl_t pipe [PIPE_D];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_addr <= '0;
            for (int i = 0; i < PIPE_D; i++) begin
                pipe[i] <= PIX_CTL_IDLE;
            end
        end else begin
            ram_addr <= addr_next;
            pipe[0]  <= ctl0;
            for (int i = 1; i < PIPE_D; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Output stage: control word now lines up with ram_rdata
    pix_ctl_t    ctl_q;
    logic [23:0] pix_rgb;

    always_comb begin
        ctl_q   = pipe[PIPE_D-1];
        pix_rgb = '0;
        if (ctl_q.active) begin
            if (!ctl_q.in_win) begin
                pix_rgb = {BORDER, BORDER, BORDER};
            end else if (ctl_q.mode == CM_RGB332) begin
                pix_rgb = rgb332_expand(ram_rdata);
            end else begin
                pix_rgb = {ram_rdata, ram_rdata, ram_rdata};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            blank       <= 1'b0;
            rgb_r       <= '0;
            rgb_g       <= '0;
            rgb_b       <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= ctl_q.hsync;
            vsync       <= ctl_q.vsync;
            blank       <= ctl_q.active;
            rgb_r       <= pix_rgb[23:16];
            rgb_g       <= pix_rgb[15:8];
            rgb_b       <= pix_rgb[7:0];
            frame_start <= ctl_q.frame_start;
        end
    end

    assign sync = 1'b0;

endmodule
